// File: rtl/sfifo_defs.sv
// Shared defaults for the SFIFO command path.
// Holds the FIFO geometry defaults, the base-period floor and the tick pulse
// width used by sfifo_core and bp_tick_gen.
package sfifo_defs;

    localparam int unsigned SFIFO_DW_DEF  = 16;
    localparam int unsigned SFIFO_AW_DEF  = 6;
    localparam int unsigned AFULL_TH_DEF  = 56;
    localparam int unsigned BP_W_DEF      = 16;
    localparam int unsigned BP_MIN_PERIOD = 4;
    localparam int unsigned TICK_HI_DEF   = 2;

endpackage

// File: rtl/bp_tick_gen.sv
// Base-period tick generator: reloadable down-counter plus pulse stretcher.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   en_i            enable; low holds the counter at its reload value
//   period_i        period in clocks, floored at BP_MIN_PERIOD, sampled on reload
//   tick_o          registered tick, high for TICK_HI cycles per period
module bp_tick_gen
    import sfifo_defs::*;
#(
    parameter int unsigned BP_W    = BP_W_DEF,
    parameter int unsigned TICK_HI = TICK_HI_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [BP_W-1:0] period_i,
    output logic            tick_o
);

    localparam int unsigned HW = $clog2(TICK_HI + 1);

    logic [BP_W-1:0] reload_val;
    logic [BP_W-1:0] cnt_q, cnt_d;
    logic [HW-1:0]   hi_q, hi_d;
    logic            tick_q, tick_d;

    // Counter load value is P-1 with P = max(period_i, BP_MIN_PERIOD)
    always_comb begin
        if (period_i < BP_W'(BP_MIN_PERIOD)) begin
            reload_val = BP_W'(BP_MIN_PERIOD - 1);
        end else begin
            reload_val = period_i - BP_W'(1);
        end
    end

    // Next-state: reload on zero and start a pulse; hi_q counts remaining high cycles
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        tick_d = 1'b0;
        if (!en_i) begin
            cnt_d  = reload_val;
            hi_d   = '0;
        end else if (cnt_q == '0) begin
            cnt_d  = reload_val;
            hi_d   = HW'(TICK_HI - 1);
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q - BP_W'(1);
            if (hi_q != '0) begin
                hi_d   = hi_q - HW'(1);
                tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/sfifo_core.sv
// Synchronous command FIFO with first-word-fall-through read and BP tick output.
// Optional saturating error counters are built when SFIFO_CORE_ERR_CNT_EN is defined;
// otherwise ovf_cnt_o/udf_cnt_o are tied to 0.
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   clr_i                   synchronous flush (wins over same-cycle wr/rd)
//   wr_i, wr_data_i         write strobe and data
//   full_o, afull_o         level == depth, level >= AFULL_TH
//   sfifo_rd_i              pop strobe
//   sfifo_empty_o, sfifo_do empty flag and FWFT head word
//   level_o                 occupancy
//   ovf_o, udf_o            sticky dropped-write / empty-pop flags
//   bp_en_i, bp_period_i    BP tick enable and period
//   sfifo_bp_tick_o         BP tick pulse
//   ovf_cnt_o, udf_cnt_o    saturating error counts (optional)
module sfifo_core
    import sfifo_defs::*;
#(
    parameter int unsigned SFIFO_DW = SFIFO_DW_DEF,
    parameter int unsigned SFIFO_AW = SFIFO_AW_DEF,
    parameter int unsigned AFULL_TH = AFULL_TH_DEF,
    parameter int unsigned BP_W     = BP_W_DEF,
    parameter int unsigned TICK_HI  = TICK_HI_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                clr_i,
    input  logic                wr_i,
    input  logic [SFIFO_DW-1:0] wr_data_i,
    output logic                full_o,
    output logic                afull_o,
    input  logic                sfifo_rd_i,
    output logic                sfifo_empty_o,
    output logic [SFIFO_DW-1:0] sfifo_do,
    output logic [SFIFO_AW:0]   level_o,
    output logic                ovf_o,
    output logic                udf_o,
    input  logic                bp_en_i,
    input  logic [BP_W-1:0]     bp_period_i,
    output logic                sfifo_bp_tick_o,
    output logic [7:0]          ovf_cnt_o,
    output logic [7:0]          udf_cnt_o
);

    localparam int unsigned DEPTH = 1 << SFIFO_AW;
    localparam int unsigned LW    = SFIFO_AW + 1;

    logic [SFIFO_DW-1:0] mem_q [DEPTH];
    logic [SFIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [SFIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SFIFO_AW:0]   level_q, level_d;
    logic                full_q, full_d;
    logic                afull_q, afull_d;
    logic                empty_q, empty_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                rd_acc, wr_acc, wr_drop, rd_empty;

    // Accept decisions; a same-cycle pop frees a slot for a write into a full FIFO
    always_comb begin
        rd_acc   = sfifo_rd_i & ~empty_q & ~clr_i;
        wr_acc   = wr_i & (~full_q | rd_acc) & ~clr_i;
        wr_drop  = wr_i & ~wr_acc & ~clr_i;
        rd_empty = sfifo_rd_i & empty_q & ~clr_i;
    end

    // Pointer, level and flag next-state; flags are registered from level_d
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + SFIFO_AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + SFIFO_AW'(1);
            if (wr_acc && !rd_acc) begin
                level_d = level_q + LW'(1);
            end else if (!wr_acc && rd_acc) begin
                level_d = level_q - LW'(1);
            end
            if (wr_drop)  ovf_d = 1'b1;
            if (rd_empty) udf_d = 1'b1;
        end
        full_d  = (level_d == LW'(DEPTH));
        afull_d = (level_d >= LW'(AFULL_TH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; head word is read combinationally for FWFT
    always_ff @(posedge wb_clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign sfifo_do      = mem_q[rd_ptr_q];
    assign full_o        = full_q;
    assign afull_o       = afull_q;
    assign sfifo_empty_o = empty_q;
    assign level_o       = level_q;
    assign ovf_o         = ovf_q;
    assign udf_o         = udf_q;

`ifdef SFIFO_CORE_ERR_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0] udf_cnt_q, udf_cnt_d;

    // Saturating error counters
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (clr_i) begin
            ovf_cnt_d = '0;
            udf_cnt_d = '0;
        end else begin
            if (wr_drop && ovf_cnt_q != 8'hFF)  ovf_cnt_d = ovf_cnt_q + 8'd1;
            if (rd_empty && udf_cnt_q != 8'hFF) udf_cnt_d = udf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
    assign udf_cnt_o = udf_cnt_q;
`else
    assign ovf_cnt_o = '0;
    assign udf_cnt_o = '0;
`endif

    bp_tick_gen #(
        .BP_W    (BP_W),
        .TICK_HI (TICK_HI)
    ) u_bp_tick_gen (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .en_i     (bp_en_i),
        .period_i (bp_period_i),
        .tick_o   (sfifo_bp_tick_o)
    );

endmodule

// File: tb/tb_sfifo_core.sv
module tb_sfifo_core;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        clr_i;
    logic        wr_i;
    logic [15:0] wr_data_i;
    logic        full_o;
    logic        afull_o;
    logic        sfifo_rd_i;
    logic        sfifo_empty_o;
    logic [15:0] sfifo_do;
    logic [6:0]  level_o;
    logic        ovf_o;
    logic        udf_o;
    logic        bp_en_i;
    logic [15:0] bp_period_i;
    logic        sfifo_bp_tick_o;
    logic [7:0]  ovf_cnt_o;
    logic [7:0]  udf_cnt_o;

    sfifo_core dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .clr_i           (clr_i),
        .wr_i            (wr_i),
        .wr_data_i       (wr_data_i),
        .full_o          (full_o),
        .afull_o         (afull_o),
        .sfifo_rd_i      (sfifo_rd_i),
        .sfifo_empty_o   (sfifo_empty_o),
        .sfifo_do        (sfifo_do),
        .level_o         (level_o),
        .ovf_o           (ovf_o),
        .udf_o           (udf_o),
        .bp_en_i         (bp_en_i),
        .bp_period_i     (bp_period_i),
        .sfifo_bp_tick_o (sfifo_bp_tick_o),
        .ovf_cnt_o       (ovf_cnt_o),
        .udf_cnt_o       (udf_cnt_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        rd;
        logic [6:0]  lvl;
        logic        emp;
        logic        udf;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    int          m_oc  = 0;
    int          m_uc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_oc  = 0;
        m_uc  = 0;
    endtask

    // Compare every FIFO output against the bench model
    task automatic check_all(input string tag);
        chk({tag, " level"}, 32'(level_o), 32'(sb.size()));
        chk({tag, " empty"}, 32'(sfifo_empty_o), 32'(sb.size() == 0));
        chk({tag, " full"},  32'(full_o),  32'(sb.size() == 64));
        chk({tag, " afull"}, 32'(afull_o), 32'(sb.size() >= 56));
        chk({tag, " ovf"},   32'(ovf_o),   32'(m_ovf));
        chk({tag, " udf"},   32'(udf_o),   32'(m_udf));
`ifdef SFIFO_CORE_ERR_CNT_EN
        chk({tag, " ovf_cnt"}, 32'(ovf_cnt_o), 32'(m_oc));
        chk({tag, " udf_cnt"}, 32'(udf_cnt_o), 32'(m_uc));
`else
        chk({tag, " ovf_cnt"}, 32'(ovf_cnt_o), 32'd0);
        chk({tag, " udf_cnt"}, 32'(udf_cnt_o), 32'd0);
`endif
        if (sb.size() != 0) chk({tag, " head"}, 32'(sfifo_do), 32'(sb[0]));
    endtask

    // One clock: drive at negedge, update scoreboard, sample at following negedge
    task automatic cycle(input logic clr, input logic wr, input logic [15:0] wd, input logic rd);
        bit racc;
        bit wacc;
        clr_i      = clr;
        wr_i       = wr;
        wr_data_i  = wd;
        sfifo_rd_i = rd;
        if (clr) begin
            model_reset();
        end else begin
            racc = rd && (sb.size() != 0);
            wacc = wr && ((sb.size() < 64) || racc);
            if (rd && !racc) begin
                m_udf = 1'b1;
                if (m_uc < 255) m_uc++;
            end
            if (wr && !wacc) begin
                m_ovf = 1'b1;
                if (m_oc < 255) m_oc++;
            end
            if (racc) begin
                chk("pop data", 32'(sfifo_do), 32'(sb[0]));
                void'(sb.pop_front());
            end
            if (wacc) sb.push_back(wd);
        end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        clr_i      = 1'b0;
        wr_i       = 1'b0;
        sfifo_rd_i = 1'b0;
    endtask

    vec_t vec[10];

    initial begin
        vec[0] = '{1'b1, 16'h1111, 1'b0, 7'd1, 1'b0, 1'b0};
        vec[1] = '{1'b1, 16'h2222, 1'b0, 7'd2, 1'b0, 1'b0};
        vec[2] = '{1'b1, 16'h3333, 1'b0, 7'd3, 1'b0, 1'b0};
        vec[3] = '{1'b0, 16'h0000, 1'b1, 7'd2, 1'b0, 1'b0};
        vec[4] = '{1'b0, 16'h0000, 1'b1, 7'd1, 1'b0, 1'b0};
        vec[5] = '{1'b0, 16'h0000, 1'b1, 7'd0, 1'b1, 1'b0};
        vec[6] = '{1'b1, 16'hABCD, 1'b1, 7'd1, 1'b0, 1'b1};
        vec[7] = '{1'b0, 16'h0000, 1'b1, 7'd0, 1'b1, 1'b1};
        vec[8] = '{1'b1, 16'h5A5A, 1'b1, 7'd1, 1'b0, 1'b1};
        vec[9] = '{1'b0, 16'h0000, 1'b1, 7'd0, 1'b1, 1'b1};

        wb_rst_i    = 1'b1;
        clr_i       = 1'b0;
        wr_i        = 1'b0;
        wr_data_i   = '0;
        sfifo_rd_i  = 1'b0;
        bp_en_i     = 1'b0;
        bp_period_i = 16'd10;

        #1;
        chk("reset level", 32'(level_o), 32'd0);
        chk("reset empty", 32'(sfifo_empty_o), 32'd1);
        chk("reset full",  32'(full_o), 32'd0);
        chk("reset afull", 32'(afull_o), 32'd0);
        chk("reset ovf",   32'(ovf_o), 32'd0);
        chk("reset udf",   32'(udf_o), 32'd0);
        chk("reset tick",  32'(sfifo_bp_tick_o), 32'd0);

        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check_all("post reset");

        // FWFT ordering, empty pops and write+pop on empty
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, vec[i].wr, vec[i].wd, vec[i].rd);
            chk($sformatf("vec%0d level", i), 32'(level_o), 32'(vec[i].lvl));
            chk($sformatf("vec%0d empty", i), 32'(sfifo_empty_o), 32'(vec[i].emp));
            chk($sformatf("vec%0d udf", i), 32'(udf_o), 32'(vec[i].udf));
            check_all($sformatf("vec%0d", i));
        end

        // Flush wins over same-cycle write and pop
        cycle(1'b1, 1'b1, 16'h7777, 1'b1);
        chk("clr udf", 32'(udf_o), 32'd0);
        check_all("clr");

        // Fill to full, watching afull threshold
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
            check_all($sformatf("fill%0d", i));
        end
        chk("full level", 32'(level_o), 32'd64);
        cycle(1'b0, 1'b1, 16'hDEAD, 1'b0);
        chk("drop ovf", 32'(ovf_o), 32'd1);
        check_all("drop");

        // Full with simultaneous write and pop
        cycle(1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("full wr+rd level", 32'(level_o), 32'd64);
        check_all("full wr+rd");

        // Drain; scoreboard proves BEEF landed at the tail
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b0, 16'h0000, 1'b1);
            check_all($sformatf("drain%0d", i));
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        check_all("empty pop");

        // BP ticks, period 10
        bp_en_i = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            chk($sformatf("bp10 k%0d", k), 32'(sfifo_bp_tick_o),
                32'((k >= 10) && ((k % 10 == 0) || (k % 10 == 1))));
        end
        bp_en_i     = 1'b0;
        bp_period_i = 16'd1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("bp off", 32'(sfifo_bp_tick_o), 32'd0);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);

        // Period below floor runs at 4 clocks
        bp_en_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            chk($sformatf("bp1 k%0d", k), 32'(sfifo_bp_tick_o),
                32'((k >= 4) && ((k % 4 == 0) || (k % 4 == 1))));
        end
        // First high cycle of a pulse: dropping enable must truncate it
        bp_en_i = 1'b0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("bp truncate", 32'(sfifo_bp_tick_o), 32'd0);

        // Asynchronous reset in the middle of a burst
        bp_en_i = 1'b1;
        cycle(1'b0, 1'b1, 16'h0101, 1'b0);
        cycle(1'b0, 1'b1, 16'h0202, 1'b0);
        cycle(1'b0, 1'b1, 16'h0303, 1'b0);
        wr_i      = 1'b1;
        wr_data_i = 16'h0404;
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("async level", 32'(level_o), 32'd0);
        chk("async empty", 32'(sfifo_empty_o), 32'd1);
        chk("async full",  32'(full_o), 32'd0);
        chk("async ovf",   32'(ovf_o), 32'd0);
        chk("async udf",   32'(udf_o), 32'd0);
        chk("async tick",  32'(sfifo_bp_tick_o), 32'd0);
        model_reset();
        bp_en_i = 1'b0;
        wr_i    = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check_all("after async");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfifo_core.md
Name: sfifo_core

Overview:
Synchronous command FIFO with first-word-fall-through (FWFT) read and a base-period (BP) tick generator.
- Sits directly upstream of the WISHBONE SFIFO register interface.
  - The host-side command stream writes 16-bit words in.
  - The interface pops them via sfifo_rd_i and samples sfifo_do.
  - The interface counts the BP tick edges it receives.
- One clock domain; the FIFO head is always visible on sfifo_do while not empty.

Parameters:
SFIFO_DW, 16, FIFO word width
SFIFO_AW, 6, FIFO address width; depth = 2**SFIFO_AW (64)
AFULL_TH, 56, level at or above which afull_o asserts
BP_W, 16, width of the BP period value
TICK_HI, 2, cycles sfifo_bp_tick_o stays high per tick

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  asynchronous, active-high reset
clr_i  in  1  synchronous flush: pointers, level and sticky flags to 0
wr_i  in  1  write strobe, one word per cycle
wr_data_i  in  SFIFO_DW  write data
full_o  out  1  level == 2**SFIFO_AW
afull_o  out  1  level >= AFULL_TH
sfifo_rd_i  in  1  pop strobe from the register interface
sfifo_empty_o  out  1  level == 0
sfifo_do  out  SFIFO_DW  head word; valid while sfifo_empty_o = 0
level_o  out  SFIFO_AW+1  current occupancy
ovf_o  out  1  sticky: a write was dropped
udf_o  out  1  sticky: a pop was attempted while empty
bp_en_i  in  1  BP tick generator enable
bp_period_i  in  BP_W  BP period in clocks
sfifo_bp_tick_o  out  1  BP tick level pulse
ovf_cnt_o  out  8  dropped-write count (feature only)
udf_cnt_o  out  8  empty-pop count (feature only)

Behaviour:
- Reset (async, wb_rst_i = 1):
  - Pointers, level, ovf_o, udf_o, the BP counter and sfifo_bp_tick_o all go to 0.
  - sfifo_empty_o = 1, full_o = 0, afull_o = 0.
  - Memory contents are not reset; sfifo_do is don't-care while empty.
- Storage: register/distributed array with a combinational read at rd_ptr, giving FWFT. A write becomes visible on sfifo_do the cycle after wr_i.
- Pointers: SFIFO_AW bits with natural wrap. Level is held in a separate SFIFO_AW+1 bit counter.
- Accept rules:
  - rd_acc = sfifo_rd_i & ~empty.
  - wr_acc = wr_i & (~full | rd_acc). A simultaneous pop frees the slot, so the write is accepted when full.
- Level update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Boundary cases:
  - Empty with simultaneous wr/rd: the write is accepted, the pop is ignored, udf_o is set, and the word appears next cycle.
  - Full with wr_i and no rd_acc: the word is dropped and ovf_o is set.
  - ovf_o and udf_o clear only on reset or clr_i.
- clr_i has priority over same-cycle wr_i/sfifo_rd_i; neither is accepted.
- BP generator:
  - Effective period P = max(bp_period_i, 4). bp_period_i is sampled at each reload.
  - A down-counter loads P-1 and decrements each cycle while bp_en_i = 1.
  - When it reaches 0 it reloads, and sfifo_bp_tick_o goes high for TICK_HI cycles starting the next cycle.
  - The first tick after bp_en_i rises comes P cycles later; ticks then repeat every P cycles. TICK_HI must be < 4.
  - bp_en_i = 0: the counter holds at reload, sfifo_bp_tick_o is forced low next cycle, and any in-progress high pulse is truncated.
- No output depends combinationally on wr_i. sfifo_do depends only on registered rd_ptr and the memory.

Optional Feature:
Macro SFIFO_CORE_ERR_CNT_EN.
- Defined: ovf_cnt_o and udf_cnt_o are 8-bit saturating counters (stop at 255).
  - They increment on each dropped write and each empty pop respectively.
  - They clear on reset or clr_i.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Decomposition:
- Shared package/header sfifo_defs: SFIFO_DW and SFIFO_AW defaults, the BP minimum period constant (4), and the TICK_HI default.
- Sub-module bp_tick_gen holds the BP counter and pulse stretcher. The FIFO logic stays in the top module.

Test Plan:
- Write 0x1111, 0x2222, 0x3333 then pop three times -> sfifo_do shows 0x1111 one cycle after the first write, then 0x2222, 0x3333. sfifo_empty_o = 1 after the third pop.
- Write 64 words -> full_o = 1, level_o = 64, afull_o = 1 from level 56. A 65th write is dropped, ovf_o = 1, and with the feature ovf_cnt_o = 1.
- Full FIFO with wr_i and sfifo_rd_i in the same cycle -> level stays 64, the new word lands at the tail, ovf_o unchanged.
- Empty FIFO with sfifo_rd_i and wr_i 0xABCD in the same cycle -> udf_o = 1, level_o = 1 next cycle, sfifo_do = 0xABCD.
- bp_period_i = 10, bp_en_i raised -> ticks high for 2 cycles every 10 cycles. bp_period_i = 1 -> a period of 4 clocks. bp_en_i dropped mid-pulse -> low next cycle.
- Assert wb_rst_i asynchronously mid-burst -> all outputs return to reset values without a clock edge. After release the FIFO reads as empty.
